// File: rtl/sequenciador_execucao.sv
// Execution sequencer for a single-cycle CPU: gates PC advance and
// register/memory commits on operator confirmation, I/O waits and HLT.
// Also counts committed instructions, saturating at 16'hFFFF.
module sequenciador_execucao (
  input  logic        clock,
  input  logic        reset,
  input  logic        confirm,
  input  logic        hlt,
  input  logic        io_req,
  input  logic        step_mode,
  output logic        pc_en,
  output logic        io_latch,
  output logic        halted,
  output logic [1:0]  estado,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    WAIT_IO = 2'b10,
    HALTED  = 2'b11
  } state_t;

  state_t state, next_state;
  logic   conf_q;
  logic   conf_edge;

  // Rising edge of the already-debounced confirm level.
  assign conf_edge = confirm & ~conf_q;

  // State code and halt flag come straight from the state register.
  assign estado = state;
  assign halted = (state == HALTED);

  // Next-state and commit decode; everything is forced idle while reset is high.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would infer a latch.
    next_state = state;
    pc_en      = 1'b0;
    io_latch   = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (conf_edge) next_state = RUN;
        end
        RUN: begin
          // HLT wins over I/O; a confirm edge in the I/O-entry cycle is dropped.
          if (hlt) begin
            next_state = HALTED;
          end else if (io_req) begin
            next_state = WAIT_IO;
          end else begin
            pc_en = step_mode ? conf_edge : 1'b1;
          end
        end
        WAIT_IO: begin
          // The exit cycle both captures switch data and commits the instruction.
          if (conf_edge) begin
            pc_en      = 1'b1;
            io_latch   = 1'b1;
            next_state = RUN;
          end
        end
        HALTED: begin
          next_state = HALTED;
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  // State, confirm history and commit counter registers.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state       <= IDLE;
      // Reset to 1 so a confirm held through reset is not seen as a press.
      conf_q      <= 1'b1;
      instr_count <= 16'd0;
    end else begin
      state  <= next_state;
      conf_q <= confirm;
      if (pc_en && (instr_count != 16'hFFFF)) begin
        instr_count <= instr_count + 16'd1;
      end
    end
  end

endmodule
